// File: rtl/arb_pkg.sv
// Shared constants, state type and helpers for the 4-way round-robin arbiter.
package arb_pkg;
  localparam int NREQ  = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_e;

  function automatic logic [IDX_W-1:0] oh_to_idx(input logic [NREQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/arb_rr4_sel_rr_pick.sv
// Combinational round-robin picker: first eligible request after Ptr, wrapping,
// with Ptr itself searched last.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  Req,
  input  logic [IDX_W-1:0] Ptr,
  input  logic [NREQ-1:0]  Mask,
  output logic [NREQ-1:0]  Pick,
  output logic             Any
);
  logic [NREQ-1:0] elig;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_elig
      assign elig[gi] = Req[gi] & ~Mask[gi];
    end
  endgenerate

  assign Any = |elig;

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    Pick  = '0;
    found = 1'b0;
    idx   = '0;
    // Offset NREQ wraps back to Ptr, so the last winner is considered last.
    for (int k = 1; k <= NREQ; k++) begin
      idx = Ptr + IDX_W'(k);
      if (!found && elig[idx]) begin
        Pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/arb_rr4_sel.sv
// 4-requester round-robin arbiter with multi-beat grant hold and registered one-hot grant.
// Optional forced release after TIMEOUT cycles when ARB_TIMEOUT_EN is defined.
module arb_rr4_sel
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NREQ-1:0]  Req,
  input  logic [NREQ-1:0]  Last,
  input  logic             Stall,
  output logic [NREQ-1:0]  GrantOH,
  output logic [IDX_W-1:0] GrantIdx,
  output logic             Busy,
  output logic             Timeout
);
  generate
    if (TIMEOUT < 2 || TIMEOUT > (1 << CNT_W) - 1) begin : g_bad_timeout
      $error("arb_rr4_sel: TIMEOUT out of range 2..255");
    end
  endgenerate

  arb_state_e       state_reg, state_next;
  logic [NREQ-1:0]  grant_reg, grant_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic             owner_req, owner_last, force_rel, rel;
  logic [NREQ-1:0]  mask, pick;
  logic             pick_any;

  assign owner_req  = |(Req & grant_reg);
  assign owner_last = |(Req & Last & grant_reg);

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             timeout_reg, timeout_next;

  assign force_rel = (state_reg == ARB_OWNED) && owner_req && !owner_last &&
                     (cnt_reg == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_next     = cnt_reg;
    timeout_next = 1'b0;
    if (!Stall) begin
      timeout_next = force_rel;
      if (state_reg == ARB_IDLE || rel) begin
        if (pick_any) cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign Timeout = timeout_reg;
`else
  assign force_rel = 1'b0;
  assign Timeout   = 1'b0;
`endif

  assign rel = (state_reg == ARB_OWNED) && (!owner_req || owner_last || force_rel);

  // A completed or revoked owner sits out the immediate re-arbitration.
  assign mask = (owner_last || force_rel) ? grant_reg : '0;

  rr_pick u_pick (
    .Req  (Req),
    .Ptr  (ptr_reg),
    .Mask (mask),
    .Pick (pick),
    .Any  (pick_any)
  );

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    if (!Stall && (state_reg == ARB_IDLE || rel)) begin
      if (pick_any) begin
        state_next = ARB_OWNED;
        grant_next = pick;
        ptr_next   = oh_to_idx(pick);
      end else begin
        state_next = ARB_IDLE;
        grant_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ARB_IDLE;
      grant_reg <= '0;
      ptr_reg   <= IDX_W'(NREQ - 1);
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign GrantOH  = grant_reg;
  assign GrantIdx = oh_to_idx(grant_reg);
  assign Busy     = |grant_reg;
endmodule

// File: tb/tb_arb_rr4_sel.sv
// Self-checking bench for arb_rr4_sel: directed scenarios plus random traffic
// against a behavioural owner/pointer model. Honours ARB_TIMEOUT_EN if defined.
module tb_arb_rr4_sel;
  localparam int TMO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] Req = '0;
  logic [3:0] Last = '0;
  logic       Stall = 1'b0;
  logic [3:0] GrantOH;
  logic [1:0] GrantIdx;
  logic       Busy;
  logic       Timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: owner index (-1 = idle), last winner, hold counter.
  int m_owner = -1;
  int m_ptr = 3;
  int m_cnt = 0;
  bit m_tmo = 1'b0;

  arb_rr4_sel #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Req      (Req),
    .Last     (Last),
    .Stall    (Stall),
    .GrantOH  (GrantOH),
    .GrantIdx (GrantIdx),
    .Busy     (Busy),
    .Timeout  (Timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_vec();
    logic [3:0] g;
    logic [1:0] ix;
    g  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    ix = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    return {g, ix, (m_owner >= 0), m_tmo};
  endfunction

  function automatic logic [7:0] got_vec();
    return {GrantOH, GrantIdx, Busy, Timeout};
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 3;
    m_cnt   = 0;
    m_tmo   = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] l, input logic s);
    bit rel;
    int masked;
    int nxt;
    m_tmo = 1'b0;
    if (s) return;
    rel    = (m_owner < 0);
    masked = -1;
    if (m_owner >= 0) begin
      if (!r[m_owner]) rel = 1'b1;
      else if (l[m_owner]) begin rel = 1'b1; masked = m_owner; end
      else if (TMO_EN && m_cnt == TMO - 1) begin rel = 1'b1; masked = m_owner; m_tmo = 1'b1; end
    end
    if (rel) begin
      nxt = -1;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (nxt < 0 && r[c] && c != masked) nxt = c;
      end
      m_owner = nxt;
      if (nxt >= 0) begin
        m_ptr = nxt;
        m_cnt = 0;
      end
    end else begin
      m_cnt++;
    end
  endtask

  // Apply inputs, advance one clock (model follows), settle 1 time unit past the edge.
  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic s);
    Req = r; Last = l; Stall = s;
    @(posedge clk);
    model_step(r, l, s);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got_vec() !== exp_vec()) begin failures++; $display("FAIL reset_state cyc=%0d got=%b exp=%b", cyc, got_vec(), exp_vec()); end
    reset_n = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0);
    checks++;
    if (got_vec() !== exp_vec()) begin failures++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, got_vec(), exp_vec()); end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 4'b1111, 1'b0);
      checks++;
      if (got_vec() !== exp_vec()) begin failures++; $display("FAIL rr_model cyc=%0d got=%b exp=%b", cyc, got_vec(), exp_vec()); end
      checks++;
      if (GrantOH !== seq[i]) begin failures++; $display("FAIL rr_sequence step=%0d got=%b exp=%b", i, GrantOH, seq[i]); end
    end
  endtask

  task automatic test_abort();
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0100, 4'b0000, 1'b0);
    checks++;
    if (GrantOH !== 4'b0100 || got_vec() !== exp_vec()) begin failures++; $display("FAIL abort_grant cyc=%0d got=%b exp=%b", cyc, got_vec(), exp_vec()); end
    drive(4'b0000, 4'b0000, 1'b0);
    checks++;
    if (GrantOH !== 4'b0000 || got_vec() !== exp_vec()) begin failures++; $display("FAIL abort_release cyc=%0d got=%b exp=%b", cyc, got_vec(), exp_vec()); end
  endtask

  task automatic test_hold();
    drive(4'b0010, 4'b0000, 1'b0);
    checks++;
    if (got_vec() !== exp_vec()) begin failures++; $display("FAIL hold_grant cyc=%0d got=%b exp=%b", cyc, got_vec(), exp_vec()); end
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 4'b0000, 1'b0);
      checks++;
      if (got_vec() !== exp_vec()) begin failures++; $display("FAIL hold_cycle cyc=%0d got=%b exp=%b", cyc, got_vec(), exp_vec()); end
    end
    drive(4'b1111, 4'b0010, 1'b0);
    checks++;
    if (got_vec() !== exp_vec()) begin failures++; $display("FAIL hold_last cyc=%0d got=%b exp=%b", cyc, got_vec(), exp_vec()); end
`ifndef ARB_TIMEOUT_EN
    checks++;
    if (GrantOH !== 4'b0100) begin failures++; $display("FAIL hold_handoff got=%b exp=0100", GrantOH); end
`endif
  endtask

  task automatic test_stall();
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b0100, 4'b0000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(4'b1111, 4'b0100, 1'b1);
      checks++;
      if (GrantOH !== 4'b0100 || got_vec() !== exp_vec()) begin failures++; $display("FAIL stall_hold cyc=%0d got=%b exp=%b", cyc, got_vec(), exp_vec()); end
    end
    drive(4'b1111, 4'b0100, 1'b0);
    checks++;
    if (GrantOH !== 4'b1000 || got_vec() !== exp_vec()) begin failures++; $display("FAIL stall_release cyc=%0d got=%b exp=%b", cyc, got_vec(), exp_vec()); end
  endtask

  task automatic test_timeout();
    drive(4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(4'b0011, 4'b0000, 1'b0);
      checks++;
      if (got_vec() !== exp_vec()) begin failures++; $display("FAIL timeout_model cyc=%0d got=%b exp=%b", cyc, got_vec(), exp_vec()); end
`ifndef ARB_TIMEOUT_EN
      checks++;
      if (GrantOH !== 4'b0001 || Timeout !== 1'b0) begin failures++; $display("FAIL timeout_disabled step=%0d got=%b/%b exp=0001/0", i, GrantOH, Timeout); end
`endif
    end
  endtask

  task automatic test_async_reset();
    drive(4'b0000, 4'b0000, 1'b0);
    drive(4'b1000, 4'b0000, 1'b0);
    checks++;
    if (GrantOH !== 4'b1000 || got_vec() !== exp_vec()) begin failures++; $display("FAIL areset_pre cyc=%0d got=%b exp=%b", cyc, got_vec(), exp_vec()); end
    Req = 4'b0000;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (GrantOH !== 4'b0000 || got_vec() !== exp_vec()) begin failures++; $display("FAIL areset_async got=%b exp=%b", got_vec(), exp_vec()); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    drive(4'b1001, 4'b0000, 1'b0);
    checks++;
    if (GrantOH !== 4'b0001 || got_vec() !== exp_vec()) begin failures++; $display("FAIL areset_first_arb cyc=%0d got=%b exp=%b", cyc, got_vec(), exp_vec()); end
  endtask

  task automatic test_random();
    logic [3:0] r, l;
    logic s;
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom_range(0, 15));
      l = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      s = ($urandom_range(0, 7) == 0);
      drive(r, l, s);
      checks++;
      if (got_vec() !== exp_vec()) begin failures++; $display("FAIL random cyc=%0d req=%b last=%b stall=%b got=%b exp=%b", cyc, r, l, s, got_vec(), exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_abort();
    test_hold();
    test_stall();
    test_timeout();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arb_rr4_sel.md
ARB_RR4_SEL -- requirements
Module: arb_rr4_sel

Interface
REQ-001 Parameter: TIMEOUT, default 16, max cycles one grant may be held (range 2..255); used only with ARB_TIMEOUT_EN.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: Req  input  4  per-requester request; bit i = requester i.
REQ-005 Port: Last  input  4  per-requester final-beat flag; only meaningful with the matching Req bit.
REQ-006 Port: Stall  input  1  freezes all arbiter state when high.
REQ-007 Port: GrantOH  output  4  registered one-hot grant; all-zero means no owner; drives a one-hot-select mux whose default input is the idle path.
REQ-008 Port: GrantIdx  output  2  binary index of the owner; 0 when GrantOH is zero.
REQ-009 Port: Busy  output  1  high iff GrantOH is nonzero.
REQ-010 Port: Timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-011 Two states: IDLE (GrantOH=0) and OWNED (exactly one GrantOH bit set); GrantOH is never multi-hot.
REQ-012 Ptr (2 bits) holds the index of the most recent winner; search order Ptr+1, Ptr+2, Ptr+3, Ptr (mod 4).
REQ-013 IDLE, Stall=0, any Req set -> next cycle OWNED, GrantOH = first set Req bit in search order, Ptr := winner (1-cycle grant latency).
REQ-014 IDLE, Req=0 -> stay IDLE.
REQ-015 OWNED by g, Req[g]=1 and Last[g]=0 -> hold grant unchanged.
REQ-016 OWNED by g, release condition = (Req[g]&Last[g]) or Req[g]=0 (abort).
REQ-017 On release with Stall=0: same edge re-arbitrates over Req with bit g masked when Last[g] caused release; winner granted next cycle (back-to-back, no idle bubble); if no eligible Req -> IDLE.
REQ-018 Masked g on release: g wins only if it is the sole requester in the following cycle, not the same one.
REQ-019 Stall=1 -> GrantOH, Ptr, state and timeout counter hold; Last/Req ignored that cycle.
REQ-020 Req changes of non-owners never affect an active grant.
REQ-021 Ptr wrap: 3+1 = 0.

Reset
REQ-022 reset_n low asynchronously forces: state IDLE, GrantOH=0, GrantIdx=0, Busy=0, Timeout=0, Ptr=3 (requester 0 highest priority first), counter=0.
REQ-023 Reset asserted mid-grant drops the grant immediately, no completion; first arbitration after deassertion follows REQ-013.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN: when defined, an 8-bit counter clears on each new grant, increments each unstalled OWNED cycle; reaching TIMEOUT-1 with no release forces release per REQ-017 with g masked, and Timeout pulses the cycle GrantOH changes.
REQ-025 Without ARB_TIMEOUT_EN: no counter exists, Timeout is constant 0, grants are held indefinitely.

Structure
REQ-026 Package arb_pkg holds: NREQ=4 constant, state enum {ARB_IDLE, ARB_OWNED}, timeout counter width constant.
REQ-027 One sub-module rr_pick: combinational, inputs Req[3:0], Ptr[1:0], Mask[3:0]; outputs one-hot Pick and Any; instantiated once.
REQ-028 GrantIdx and Busy derived combinationally from registered GrantOH.

Verification
REQ-029 After reset, Req=1111 held, Last=1111 each cycle -> GrantOH sequence 0001,0010,0100,1000,0001, no idle cycles.
REQ-030 Req=0100 single cycle then Req=0 (no Last) -> GrantOH=0100 one cycle, then 0000 (abort).
REQ-031 Owner 0010 with Last=0, Req=1111, 5 cycles -> GrantOH stays 0010; Last[1]=1 -> next GrantOH=0100.
REQ-032 Stall=1 during Last[g] release cycle -> GrantOH unchanged; release occurs first cycle Stall=0.
REQ-033 reset_n pulsed low mid-grant (GrantOH=1000) -> GrantOH=0000 without waiting for clock; next Req=1001 -> GrantOH=0001.
REQ-034 ARB_TIMEOUT_EN, TIMEOUT=4, Req=0011 with Last=0 -> GrantOH=0001 for 4 cycles, then 0010 with Timeout=1 that cycle; without macro, 0001 held indefinitely, Timeout=0.
